// File: rtl/tt_um_sps_match_controller.sv
// Stone/paper/scissors match controller: edge-detected commits, one-cycle round
// evaluation, timed result display and first-to-WIN_TARGET match scoring.
module tt_um_sps_match_controller #(
  parameter int WIN_TARGET  = 3,
  parameter int SHOW_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] WIN       = 4'(WIN_TARGET);
  localparam logic [7:0] SHOW_LAST = 8'(SHOW_CYCLES - 1);

  localparam logic [1:0] MV_STONE    = 2'b00;
  localparam logic [1:0] MV_PAPER    = 2'b01;
  localparam logic [1:0] MV_SCISSORS = 2'b10;
  localparam logic [1:0] MV_INVALID  = 2'b11;

  localparam logic [1:0] RES_TIE = 2'b00;
  localparam logic [1:0] RES_P1  = 2'b01;
  localparam logic [1:0] RES_P2  = 2'b10;

  typedef enum logic [2:0] {IDLE, COLLECT, EVAL, SHOW, OVER} state_t;

  state_t     state_q, state_d;
  logic [7:0] show_cnt_q, show_cnt_d;
  logic [1:0] p1_move_q, p1_move_d;
  logic [1:0] p2_move_q, p2_move_d;
  logic       p1_lock_q, p1_lock_d;
  logic       p2_lock_q, p2_lock_d;
  logic [1:0] result_q, result_d;
  logic       result_valid_q, result_valid_d;
  logic [3:0] p1_score_q, p1_score_d;
  logic [3:0] p2_score_q, p2_score_d;
  logic       match_over_q, match_over_d;
  logic [1:0] winner_q, winner_d;

  logic       p1_commit_prev, p2_commit_prev, start_prev;
  logic       p1_commit_edge, p2_commit_edge, start_edge;
  logic       abort;
  logic [1:0] p1_in_move, p2_in_move;
  logic [1:0] round_result;
  logic       unused_ok;

  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return (a == MV_STONE    && b == MV_SCISSORS) ||
           (a == MV_SCISSORS && b == MV_PAPER)    ||
           (a == MV_PAPER    && b == MV_STONE);
  endfunction

  assign p1_in_move     = ui_in[1:0];
  assign p2_in_move     = ui_in[4:3];
  assign abort          = ui_in[7];
  assign p1_commit_edge = ui_in[2] & ~p1_commit_prev;
  assign p2_commit_edge = ui_in[5] & ~p2_commit_prev;
  assign start_edge     = ui_in[6] & ~start_prev;
  assign unused_ok      = &{1'b0, uio_in};

  assign round_result = (p1_move_q == p2_move_q)     ? RES_TIE :
                        beats(p1_move_q, p2_move_q)  ? RES_P1  : RES_P2;

  // Edge detectors keep sampling while ena is low, so an edge seen then is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_commit_prev <= 1'b0;
      p2_commit_prev <= 1'b0;
      start_prev     <= 1'b0;
    end else begin
      p1_commit_prev <= ui_in[2];
      p2_commit_prev <= ui_in[5];
      start_prev     <= ui_in[6];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      show_cnt_q     <= 8'd0;
      p1_move_q      <= MV_STONE;
      p2_move_q      <= MV_STONE;
      p1_lock_q      <= 1'b0;
      p2_lock_q      <= 1'b0;
      result_q       <= RES_TIE;
      result_valid_q <= 1'b0;
      p1_score_q     <= 4'd0;
      p2_score_q     <= 4'd0;
      match_over_q   <= 1'b0;
      winner_q       <= RES_TIE;
    end else begin
      state_q        <= state_d;
      show_cnt_q     <= show_cnt_d;
      p1_move_q      <= p1_move_d;
      p2_move_q      <= p2_move_d;
      p1_lock_q      <= p1_lock_d;
      p2_lock_q      <= p2_lock_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      p1_score_q     <= p1_score_d;
      p2_score_q     <= p2_score_d;
      match_over_q   <= match_over_d;
      winner_q       <= winner_d;
    end
  end

  // Abort outranks everything; start/new-match and abort share the same clearing.
  always_comb begin
    state_d        = state_q;
    show_cnt_d     = show_cnt_q;
    p1_move_d      = p1_move_q;
    p2_move_d      = p2_move_q;
    p1_lock_d      = p1_lock_q;
    p2_lock_d      = p2_lock_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    p1_score_d     = p1_score_q;
    p2_score_d     = p2_score_q;
    match_over_d   = match_over_q;
    winner_d       = winner_q;

    if (ena) begin
      if (abort || ((state_q == IDLE || state_q == OVER) && start_edge)) begin
        state_d        = abort ? IDLE : COLLECT;
        show_cnt_d     = 8'd0;
        p1_move_d      = MV_STONE;
        p2_move_d      = MV_STONE;
        p1_lock_d      = 1'b0;
        p2_lock_d      = 1'b0;
        result_d       = RES_TIE;
        result_valid_d = 1'b0;
        p1_score_d     = 4'd0;
        p2_score_d     = 4'd0;
        match_over_d   = 1'b0;
        winner_d       = RES_TIE;
      end else begin
        case (state_q)
          COLLECT: begin
            if (p1_commit_edge && !p1_lock_q && p1_in_move != MV_INVALID) begin
              p1_move_d = p1_in_move;
              p1_lock_d = 1'b1;
            end
            if (p2_commit_edge && !p2_lock_q && p2_in_move != MV_INVALID) begin
              p2_move_d = p2_in_move;
              p2_lock_d = 1'b1;
            end
            if (p1_lock_d && p2_lock_d) begin
              state_d = EVAL;
            end
          end
          EVAL: begin
            result_d       = round_result;
            result_valid_d = 1'b1;
            show_cnt_d     = 8'd0;
            state_d        = SHOW;
            if (round_result == RES_P1 && p1_score_q < WIN) begin
              p1_score_d = p1_score_q + 4'd1;
            end
            if (round_result == RES_P2 && p2_score_q < WIN) begin
              p2_score_d = p2_score_q + 4'd1;
            end
          end
          SHOW: begin
            if (show_cnt_q == SHOW_LAST) begin
              show_cnt_d     = 8'd0;
              p1_lock_d      = 1'b0;
              p2_lock_d      = 1'b0;
              result_valid_d = 1'b0;
              if (p1_score_q == WIN || p2_score_q == WIN) begin
                state_d      = OVER;
                match_over_d = 1'b1;
                winner_d     = (p1_score_q == WIN) ? RES_P1 : RES_P2;
              end else begin
                state_d = COLLECT;
              end
            end else begin
              show_cnt_d = show_cnt_q + 8'd1;
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
  end

  assign uo_out  = {winner_q, match_over_q, result_valid_q, p2_lock_q, p1_lock_q, result_q};
  assign uio_out = {p2_score_q, p1_score_q};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_sps_match_controller.sv
// Scoreboard bench for the stone/paper/scissors match controller.
module tb_tt_um_sps_match_controller;

  localparam int WIN  = 3;
  localparam int SHOW = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  typedef struct packed {
    logic [1:0] res;
    logic [7:0] scores;
  } exp_t;

  exp_t       sbq[$];
  int         total = 0;
  int         bad   = 0;
  int         m1    = 0;
  int         m2    = 0;
  logic [1:0] last_res = 2'b00;

  tt_um_sps_match_controller #(
    .WIN_TARGET (WIN),
    .SHOW_CYCLES(SHOW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [1:0] refResult(input logic [1:0] a, input logic [1:0] b);
    if (a == b) return 2'b00;
    if ((a == 2'b00 && b == 2'b10) || (a == 2'b10 && b == 2'b01) || (a == 2'b01 && b == 2'b00))
      return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic [7:0] modelScores();
    logic [3:0] s1;
    logic [3:0] s2;
    s1 = m1[3:0];
    s2 = m2[3:0];
    return {s2, s1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushRound(input logic [1:0] a, input logic [1:0] b);
    exp_t e;
    logic [1:0] r;
    r = refResult(a, b);
    if (r == 2'b01 && m1 < WIN) m1++;
    if (r == 2'b10 && m2 < WIN) m2++;
    e.res    = r;
    e.scores = modelScores();
    sbq.push_back(e);
  endtask

  // Guarantees a low sample before the commit so each call produces a fresh edge.
  task automatic applyStimulus(input logic p1c, input logic [1:0] p1m,
                               input logic p2c, input logic [1:0] p2m);
    ui_in[2] = 1'b0;
    ui_in[5] = 1'b0;
    tick();
    ui_in[1:0] = p1m;
    ui_in[2]   = p1c;
    ui_in[4:3] = p2m;
    ui_in[5]   = p2c;
    tick();
    ui_in[2] = 1'b0;
    ui_in[5] = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulseStart();
    ui_in[6] = 1'b0;
    tick();
    ui_in[6] = 1'b1;
    tick();
    ui_in[6] = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitValid(input string tag);
    exp_t e;
    int guard;
    guard = 0;
    @(negedge clk);
    while (uo_out[4] !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_valid"}, 32'(uo_out[4]), 32'd1);
    if (sbq.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'(sbq.size()), 32'd1);
    end else begin
      e = sbq.pop_front();
      last_res = e.res;
      checkOutput({tag, "_res"}, 32'(uo_out[1:0]), 32'(e.res));
      checkOutput({tag, "_score"}, 32'(uio_out), 32'(e.scores));
    end
  endtask

  task automatic checkShow(input string tag, input int exp_len);
    int n;
    n = 0;
    while (uo_out[4] === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, "_show_len"}, 32'(n), 32'(exp_len));
    checkOutput({tag, "_after_show"}, 32'(uo_out[4:2]), 32'd0);
    checkOutput({tag, "_kept_res"}, 32'(uo_out[1:0]), 32'(last_res));
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_uo", 32'(uo_out), 32'h00);
    checkOutput("reset_uio", 32'(uio_out), 32'h00);
    checkOutput("reset_oe", 32'(uio_oe), 32'hFF);
    rst_n = 1'b1;

    // Round 1: P1 paper, P2 stone a few cycles later
    pulseStart();
    checkOutput("start_uo", 32'(uo_out), 32'h00);
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b00);
    checkOutput("r1_p1_lock", 32'(uo_out[3:2]), 32'h1);
    tick();
    tick();
    pushRound(2'b01, 2'b00);
    applyStimulus(1'b0, 2'b01, 1'b1, 2'b00);
    checkOutput("r1_eval", 32'(uo_out[4:2]), 32'h3);
    waitValid("r1");
    checkShow("r1", SHOW);

    // Round 2: simultaneous scissors
    pushRound(2'b10, 2'b10);
    applyStimulus(1'b1, 2'b10, 1'b1, 2'b10);
    checkOutput("r2_both_locks", 32'(uo_out[4:2]), 32'h3);
    waitValid("r2");
    checkShow("r2", SHOW);

    // Round 3: invalid commit ignored, start ignored, re-commit while locked ignored
    applyStimulus(1'b1, 2'b11, 1'b0, 2'b00);
    checkOutput("r3_invalid", 32'(uo_out[3:2]), 32'h0);
    applyStimulus(1'b1, 2'b00, 1'b0, 2'b00);
    checkOutput("r3_stone_lock", 32'(uo_out[3:2]), 32'h1);
    pulseStart();
    checkOutput("r3_start_ignored", 32'({uo_out[3:2], uio_out}), 32'({2'b01, modelScores()}));
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b00);
    checkOutput("r3_relock", 32'(uo_out[3:2]), 32'h1);
    pushRound(2'b00, 2'b01);
    applyStimulus(1'b0, 2'b01, 1'b1, 2'b01);
    waitValid("r3");
    checkShow("r3", SHOW);

    // Round 4: P1 scissors beats paper (2-1), then abort during SHOW
    pushRound(2'b10, 2'b01);
    applyStimulus(1'b1, 2'b10, 1'b1, 2'b01);
    waitValid("r4");
    ui_in[7] = 1'b1;
    @(negedge clk);
    ui_in[7] = 1'b0;
    m1 = 0;
    m2 = 0;
    checkOutput("abort_uo", 32'(uo_out), 32'h00);
    checkOutput("abort_uio", 32'(uio_out), 32'h00);

    // ena low during SHOW stretches it
    pulseStart();
    pushRound(2'b00, 2'b10);
    applyStimulus(1'b1, 2'b00, 1'b1, 2'b10);
    waitValid("ena");
    ena = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("ena_hold", 32'({uo_out[4], uio_out}), 32'({1'b1, modelScores()}));
    ena = 1'b1;
    checkShow("ena", SHOW);

    // A commit edge while ena is low is lost
    ena = 1'b0;
    ui_in[1:0] = 2'b00;
    ui_in[2]   = 1'b1;
    tick();
    ui_in[2] = 1'b0;
    tick();
    ena = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("ena_lost_edge", 32'(uo_out[3:2]), 32'h0);

    // Asynchronous reset mid-COLLECT
    applyStimulus(1'b1, 2'b01, 1'b0, 2'b00);
    checkOutput("pre_reset_lock", 32'(uo_out[3:2]), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_uo", 32'(uo_out), 32'h00);
    checkOutput("async_reset_uio", 32'(uio_out), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    m1 = 0;
    m2 = 0;
    applyStimulus(1'b1, 2'b00, 1'b1, 2'b10);
    repeat (3) @(negedge clk);
    checkOutput("idle_ignores", 32'({uo_out, uio_out}), 32'h0);

    // P2 wins three rounds and the match
    pulseStart();
    for (int k = 0; k < WIN; k++) begin
      pushRound(2'b00, 2'b01);
      applyStimulus(1'b1, 2'b00, 1'b1, 2'b01);
      waitValid("p2win");
      checkShow("p2win", SHOW);
    end
    checkOutput("over_uo", 32'(uo_out), 32'hA2);
    checkOutput("over_uio", 32'(uio_out), 32'h30);
    applyStimulus(1'b1, 2'b10, 1'b1, 2'b00);
    repeat (6) @(negedge clk);
    checkOutput("over_frozen", 32'({uo_out, uio_out}), 32'hA230);
    pulseStart();
    m1 = 0;
    m2 = 0;
    checkOutput("restart", 32'({uo_out, uio_out}), 32'h0);
    pushRound(2'b01, 2'b00);
    applyStimulus(1'b1, 2'b01, 1'b1, 2'b00);
    waitValid("after_restart");
    checkShow("after_restart", SHOW);
    checkOutput("sb_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
